mips_datapath_gen: RTL and testbench

- Parametrised multicycle MIPS-subset datapath for the next core generation. Data width and register count are parameters.
- Adds a built-in instruction-fetch sequencer with a memory read-valid handshake. It assembles the 32-bit instruction from 32/WIDTH beats without per-byte control from the controller.
- Sits between the multicycle controller (drives alucontrol, alusrca, alusrcb, pcsource, iord, memtoreg, regdst, regwrite, pcen, fetch_start) and the external memory.

---
 rtl/mips_dp_pkg.sv | 17 +
 rtl/mips_regfile_gen.sv | 20 ++
 rtl/mips_datapath_gen.sv | 123 ++++++++++++
 tb/tb_mips_datapath_gen.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dp_pkg.sv
// mips_dp_pkg: shared ALU op codes, mux encodings and fetch FSM states for mips_datapath_gen.
package mips_dp_pkg;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_STEP  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMX4 = 2'b11;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_ZERO   = 2'b11;
  typedef enum logic [1:0] {F_IDLE, F_BEAT, F_DONE} fetch_state_e;
endpackage

// File: rtl/mips_regfile_gen.sv
// mips_regfile_gen: REGS x WIDTH register file, two combinational reads, r0 hardwired to zero.
module mips_regfile_gen #(
  parameter int WIDTH = 8,
  parameter int REGS  = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(REGS)-1:0]  ra1_i,
  input  logic [$clog2(REGS)-1:0]  ra2_i,
  input  logic [$clog2(REGS)-1:0]  wa_i,
  input  logic [WIDTH-1:0]         wd_i,
  output logic [WIDTH-1:0]         rd1_o,
  output logic [WIDTH-1:0]         rd2_o
);
  logic [WIDTH-1:0] mem_q [REGS];
  always_ff @(posedge clk)
    if (we_i && wa_i != '0) mem_q[wa_i] <= wd_i;
  assign rd1_o = ra1_i == '0 ? '0 : mem_q[ra1_i];
  assign rd2_o = ra2_i == '0 ? '0 : mem_q[ra2_i];
endmodule

// File: rtl/mips_datapath_gen.sv
// mips_datapath_gen: multicycle MIPS-subset datapath with built-in big-endian instruction fetch sequencer.
// Define MIPS_DATAPATH_GEN_OVF_EN to build the sticky signed-overflow flag (ovf tied 0 otherwise).
module mips_datapath_gen
  import mips_dp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int REGS  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] memdata,
  input  logic             mem_rvalid,
  input  logic             fetch_start,
  input  logic [2:0]       alucontrol,
  input  logic             alusrca,
  input  logic [1:0]       alusrcb,
  input  logic [1:0]       pcsource,
  input  logic             pcen,
  input  logic             iord,
  input  logic             memtoreg,
  input  logic             regdst,
  input  logic             regwrite,
  output logic [WIDTH-1:0] adr,
  output logic             mem_rd,
  output logic [WIDTH-1:0] writedata,
  output logic [31:0]      instr,
  output logic             zero,
  output logic             fetch_busy,
  output logic             fetch_done,
  output logic             ovf
);
  localparam int RA_W  = $clog2(REGS);
  localparam int BEATS = 32 / WIDTH;
  localparam int KW    = BEATS > 1 ? $clog2(BEATS) : 1;
  fetch_state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [WIDTH-1:0] pc_q, pc_d, mdr_q, a_q, b_q, aluout_q;
  logic [31:0] ir_q, ir_d;
  logic [WIDTH-1:0] rd1, rd2, wd, imm, immx4, jt, srca, srcb, sum, diff, aluresult, pcsrc_val;
  logic [RA_W-1:0] wa;
  logic busy, beat, last;
  mips_regfile_gen #(.WIDTH(WIDTH), .REGS(REGS)) u_rf (
    .clk  (clk),
    .we_i (regwrite),
    .ra1_i(ir_q[21+:RA_W]),
    .ra2_i(ir_q[16+:RA_W]),
    .wa_i (wa),
    .wd_i (wd),
    .rd1_o(rd1),
    .rd2_o(rd2)
  );
  assign wa    = regdst ? ir_q[16+:RA_W] : ir_q[11+:RA_W];
  assign wd    = memtoreg ? aluout_q : mdr_q;
  assign imm   = WIDTH'($signed(ir_q[15:0]));
  assign immx4 = imm << 2;
  assign jt    = WIDTH'({ir_q[25:0], 2'b00});
  assign srca  = alusrca ? pc_q : a_q;
  assign srcb  = alusrcb == SRCB_B ? b_q : alusrcb == SRCB_STEP ? WIDTH'(WIDTH / 8) :
                 alusrcb == SRCB_IMM ? imm : immx4;
  assign sum   = srca + srcb;
  assign diff  = srca - srcb;
  assign aluresult = alucontrol == ALU_AND ? srca & srcb :
                     alucontrol == ALU_OR  ? srca | srcb :
                     alucontrol == ALU_ADD ? sum :
                     alucontrol == ALU_SUB ? diff :
                     alucontrol == ALU_SLT ? {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)} : '0;
  assign zero      = aluresult == '0;
  assign pcsrc_val = pcsource == PCS_ALU ? aluresult : pcsource == PCS_ALUOUT ? aluout_q :
                     pcsource == PCS_JUMP ? jt : '0;
  assign busy = state_q != F_IDLE;
  assign beat = state_q == F_BEAT;
  assign last = k_q == KW'(BEATS - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= F_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q == F_IDLE ? (fetch_start ? F_BEAT : F_IDLE) :
              state_q == F_BEAT ? (mem_rvalid && last ? F_DONE : F_BEAT) : F_IDLE;
    k_d = state_q == F_IDLE ? '0 : beat && mem_rvalid && !last ? k_q + KW'(1) : k_q;
    ir_d = ir_q;
    if (beat && mem_rvalid) ir_d[(BEATS - 1 - int'(k_q)) * WIDTH +: WIDTH] = memdata;
    pc_d = state_q == F_DONE ? pc_q + WIDTH'(4) : !busy && pcen ? pcsrc_val : pc_q;
  end
  // While fetching, the sequencer owns the address bus regardless of iord.
  always_comb begin
    mem_rd     = beat;
    fetch_busy = busy;
    fetch_done = state_q == F_DONE;
    adr        = busy ? pc_q + WIDTH'(k_q) * WIDTH'(WIDTH / 8) : iord ? pc_q : aluout_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      k_q      <= '0;
      pc_q     <= '0;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      k_q      <= k_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= rd1;
      b_q      <= rd2;
      aluout_q <= aluresult;
      if (mem_rvalid && !busy) mdr_q <= memdata;
    end
  assign instr     = ir_q;
  assign writedata = b_q;
`ifdef MIPS_DATAPATH_GEN_OVF_EN
  logic ovf_q, add_ovf, sub_ovf;
  assign add_ovf = srca[WIDTH-1] == srcb[WIDTH-1] && sum[WIDTH-1] != srca[WIDTH-1];
  assign sub_ovf = srca[WIDTH-1] != srcb[WIDTH-1] && diff[WIDTH-1] != srca[WIDTH-1];
  always_ff @(posedge clk or posedge reset)
    if (reset) ovf_q <= 1'b0;
    else if ((pcen || regwrite) && ((alucontrol == ALU_ADD && add_ovf) || (alucontrol == ALU_SUB && sub_ovf)))
      ovf_q <= 1'b1;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_mips_datapath_gen.sv
// tb_mips_datapath_gen: table-driven and randomized checks of mips_datapath_gen (WIDTH=8 and WIDTH=32).
module tb_mips_datapath_gen;
`ifdef MIPS_DATAPATH_GEN_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic [7:0] memdata, md_drv, adr, writedata;
  logic mem_rvalid, fetch_start, alusrca, pcen, iord, memtoreg, regdst, regwrite;
  logic [2:0] alucontrol;
  logic [1:0] alusrcb, pcsource;
  logic mem_rd, zero, fetch_busy, fetch_done, ovf;
  logic [31:0] instr;
  logic mem_mode;
  logic [7:0] bmem [256];
  assign memdata = mem_mode ? bmem[adr] : md_drv;
  logic [31:0] md32, adr32, wd32, instr32;
  logic rv32, fs32, iord32, mem_rd32, zero32, busy32, done32, ovf32;

  mips_datapath_gen #(.WIDTH(8), .REGS(8)) u8 (
    .clk(clk), .reset(reset), .memdata(memdata), .mem_rvalid(mem_rvalid), .fetch_start(fetch_start),
    .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource), .pcen(pcen),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .adr(adr), .mem_rd(mem_rd),
    .writedata(writedata), .instr(instr), .zero(zero), .fetch_busy(fetch_busy), .fetch_done(fetch_done), .ovf(ovf)
  );
  mips_datapath_gen #(.WIDTH(32), .REGS(8)) u32 (
    .clk(clk), .reset(reset), .memdata(md32), .mem_rvalid(rv32), .fetch_start(fs32),
    .alucontrol(3'b000), .alusrca(1'b0), .alusrcb(2'b00), .pcsource(2'b00), .pcen(1'b0),
    .iord(iord32), .memtoreg(1'b0), .regdst(1'b0), .regwrite(1'b0), .adr(adr32), .mem_rd(mem_rd32),
    .writedata(wd32), .instr(instr32), .zero(zero32), .fetch_busy(busy32), .fetch_done(done32), .ovf(ovf32)
  );

  int checks = 0, errors = 0;
  logic [7:0] regs_m [8];
  logic [7:0] pc_m;
  logic [31:0] ir_m;
  bit ovf_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sx(input int v);
    return v > 127 ? v - 256 : v;
  endfunction
  function automatic int alu_m(input int op, input int a, input int b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return (a + b) % 256;
      6: return (a - b + 256) % 256;
      7: return sx(a) < sx(b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction
  function automatic bit ovf_fn(input int op, input int a, input int b);
    int s;
    s = op == 2 ? sx(a) + sx(b) : op == 6 ? sx(a) - sx(b) : 0;
    return s > 127 || s < -128;
  endfunction

  task automatic fetch(input logic [31:0] word, input bit rnd, input bit do_pcen);
    int beat = 0, n = 0;
    for (int i = 0; i < 4; i++) bmem[8'(pc_m + i)] = word[31 - 8 * i -: 8];
    mem_mode = 1'b1;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    if (do_pcen) begin
      pcen = 1'b1;
      pcsource = 2'b10;
    end
    while (!fetch_done && n < 40) begin
      chk("fetch_rd", mem_rd, 1);
      chk("fetch_adr", adr, 8'(pc_m + beat));
      mem_rvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (mem_rvalid) beat++;
      n++;
    end
    mem_rvalid = 1'b0;
    pcen = 1'b0;
    pcsource = 2'b00;
    chk("fetch_done", fetch_done, 1);
    chk("fetch_beats", beat, 4);
    chk("done_busy", fetch_busy, 1);
    @(negedge clk);
    chk("done_pulse", fetch_done, 0);
    chk("busy_clr", fetch_busy, 0);
    chk("instr", instr, word);
    iord = 1'b1;
    #1 chk("pc_after_fetch", adr, 8'(pc_m + 4));
    iord = 1'b0;
    pc_m = 8'(pc_m + 4);
    ir_m = word;
  endtask

  task automatic wreg(input logic [7:0] v, input bit to_rt);
    logic [2:0] wa;
    mem_mode = 1'b0;
    md_drv = v;
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    memtoreg = 1'b0;
    regdst = to_rt;
    regwrite = 1'b1;
    alucontrol = 3'b000;
    @(negedge clk);
    regwrite = 1'b0;
    wa = to_rt ? ir_m[18:16] : ir_m[13:11];
    if (wa != 0) regs_m[wa] = v;
    chk("ir_hold", instr, ir_m);
    @(negedge clk);
    chk("regB", writedata, regs_m[ir_m[18:16]]);
  endtask

  task automatic alu_op(input logic [2:0] op, input bit sa_pc, input logic [1:0] sb, input bit rw,
                        output logic [7:0] res);
    int a, b, s16;
    s16 = int'($signed(ir_m[15:0]));
    a = sa_pc ? int'(pc_m) : int'(regs_m[ir_m[23:21]]);
    b = sb == 0 ? int'(regs_m[ir_m[18:16]]) : sb == 1 ? 1 : sb == 2 ? (s16 & 255) : ((s16 * 4) & 255);
    res = 8'(alu_m(op, a, b));
    alucontrol = op;
    alusrca = sa_pc;
    alusrcb = sb;
    regwrite = rw;
    memtoreg = 1'b1;
    regdst = 1'b0;
    #1 chk("zero", zero, res == 0);
    @(negedge clk);
    if (rw && ovf_fn(op, a, b)) ovf_m = ovf_m | OVF_EN;
    regwrite = 1'b0;
    alucontrol = 3'b000;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    iord = 1'b0;
    #1 chk("aluout", adr, res);
    chk("ovf", ovf, ovf_m);
    chk("regB_alu", writedata, regs_m[ir_m[18:16]]);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [1:0] sb;
    logic [7:0] a, b, exp;
  } vec_t;
  vec_t tbl [12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] res;
    logic [31:0] w;
    tbl[0]  = '{3'b000, 2'b00, 8'hCA, 8'h5F, 8'h4A};
    tbl[1]  = '{3'b001, 2'b00, 8'hCA, 8'h35, 8'hFF};
    tbl[2]  = '{3'b010, 2'b00, 8'hF0, 8'h20, 8'h10};
    tbl[3]  = '{3'b110, 2'b00, 8'h10, 8'h20, 8'hF0};
    tbl[4]  = '{3'b110, 2'b00, 8'h5C, 8'h5C, 8'h00};
    tbl[5]  = '{3'b111, 2'b00, 8'h80, 8'h01, 8'h01};
    tbl[6]  = '{3'b111, 2'b00, 8'h01, 8'h80, 8'h00};
    tbl[7]  = '{3'b011, 2'b00, 8'h12, 8'h34, 8'h00};
    tbl[8]  = '{3'b100, 2'b00, 8'hFF, 8'hFF, 8'h00};
    tbl[9]  = '{3'b010, 2'b01, 8'h41, 8'h00, 8'h42};
    tbl[10] = '{3'b010, 2'b10, 8'h10, 8'h00, 8'h03};
    tbl[11] = '{3'b010, 2'b11, 8'h10, 8'h00, 8'hDC};
    reset = 1'b1;
    {mem_rvalid, fetch_start, alusrca, pcen, iord, memtoreg, regdst, regwrite, mem_mode} = '0;
    {alucontrol, alusrcb, pcsource, md_drv} = '0;
    {rv32, fs32, iord32} = '0;
    md32 = 32'h0;
    for (int i = 0; i < 256; i++) bmem[i] = 8'h00;
    for (int i = 0; i < 8; i++) regs_m[i] = 8'h00;
    pc_m = 8'h00;
    ir_m = 32'h0;
    ovf_m = 1'b0;
    @(negedge clk);
    chk("rst_instr", instr, 0);
    chk("rst_busy", fetch_busy, 0);
    chk("rst_done", fetch_done, 0);
    chk("rst_memrd", mem_rd, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_B", writedata, 0);
    iord = 1'b1;
    #1 chk("rst_pc", adr, 0);
    iord = 1'b0;
    reset = 1'b0;
    // PC := 4 + imm(12) = 0x10, then fetch the reference word with its beat address sequence
    fetch(32'h0000000C, 1'b0, 1'b0);
    alusrca = 1'b1;
    alusrcb = 2'b10;
    alucontrol = 3'b010;
    pcen = 1'b1;
    @(negedge clk);
    {pcen, alusrca, alusrcb, alucontrol} = '0;
    pc_m = 8'(alu_m(2, pc_m, 12));
    iord = 1'b1;
    #1 chk("pc_set", adr, 8'h10);
    iord = 1'b0;
    fetch(32'h20010005, 1'b0, 1'b0);
    chk("plan_instr", ir_m, 32'h20010005);
    // pcen ignored while busy, then honoured once idle
    fetch(32'h0000003F, 1'b1, 1'b1);
    pcen = 1'b1;
    pcsource = 2'b10;
    @(negedge clk);
    pcen = 1'b0;
    pcsource = 2'b00;
    pc_m = 8'((ir_m[25:0] * 4) & 255);
    iord = 1'b1;
    #1 chk("jump_pc", adr, 8'hFC);
    iord = 1'b0;
    // asynchronous reset in the middle of a fetch
    w = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) bmem[8'(pc_m + i)] = w[31 - 8 * i -: 8];
    mem_mode = 1'b1;
    mem_rvalid = 1'b1;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_ir", instr[31:16], 16'hDEAD);
    iord = 1'b1;
    #1 reset = 1'b1;
    #1 chk("mid_rst_ir", instr, 0);
    chk("mid_rst_busy", fetch_busy, 0);
    chk("mid_rst_memrd", mem_rd, 0);
    chk("mid_rst_pc", adr, 0);
    #1 reset = 1'b0;
    mem_rvalid = 1'b0;
    pc_m = 8'h00;
    ir_m = 32'h0;
    ovf_m = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", fetch_busy, 0);
    iord = 1'b0;
    for (int r = 1; r < 8; r++) begin
      fetch(32'(r) << 16, 1'b1, 1'b0);
      wreg(8'($urandom), 1'b1);
    end
    // r0 stays zero; r3 holds what was written; SUB of equal regs sets zero
    fetch(32'h00000000, 1'b0, 1'b0);
    wreg(8'hAB, 1'b1);
    chk("r0_read", writedata, 8'h00);
    fetch(32'h00630000, 1'b0, 1'b0);
    wreg(8'h5C, 1'b1);
    chk("r3_read", writedata, 8'h5C);
    alu_op(3'b110, 1'b0, 2'b00, 1'b0, res);
    chk("sub_eq", res, 8'h00);
    fetch(32'h002288F3, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      wreg(tbl[i].a, 1'b0);
      wreg(tbl[i].b, 1'b1);
      alu_op(tbl[i].op, 1'b0, tbl[i].sb, 1'b0, res);
      chk("tbl_result", res, tbl[i].exp);
    end
    wreg(8'h7F, 1'b0);
    wreg(8'h01, 1'b1);
    fetch(32'h00220000, 1'b0, 1'b0);
    alu_op(3'b010, 1'b0, 2'b00, 1'b1, res);
    chk("ovf_set", ovf, OVF_EN);
    alu_op(3'b000, 1'b0, 2'b00, 1'b1, res);
    alu_op(3'b110, 1'b0, 2'b00, 1'b1, res);
    chk("ovf_sticky", ovf, OVF_EN);
    for (int it = 0; it < 30; it++) begin
      w = $urandom;
      w[13:11] = 3'b000;
      fetch(w, 1'b1, 1'b0);
      wreg(8'($urandom), 1'b1);
      alu_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), res);
    end
    // WIDTH=32: one beat whose data arrives after three wait cycles
    md32 = 32'h8C430010;
    fs32 = 1'b1;
    @(negedge clk);
    fs32 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("w32_memrd", mem_rd32, 1);
      chk("w32_adr", adr32, 0);
      chk("w32_ir_wait", instr32, 0);
      rv32 = i == 3;
      @(negedge clk);
    end
    rv32 = 1'b0;
    chk("w32_done", done32, 1);
    @(negedge clk);
    chk("w32_instr", instr32, 32'h8C430010);
    chk("w32_busy", busy32, 0);
    iord32 = 1'b1;
    #1 chk("w32_pc", adr32, 32'h4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
